// File: rtl/tdm_demux.sv
// TDM lane de-interleaver: collects N samples per frame (ch0 marked by in_sof) and
// publishes them as one N*W word over valid/ready. Optional error counter: TDM_DEMUX_ERRCNT_EN.
module tdm_demux #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    input  logic           in_sof,
    output logic [N*W-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           err_short,
    output logic           err_overflow
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [15:0]    err_count
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t               state;
    logic [CW-1:0]        ch;
    logic [N-1:0][W-1:0]  staging;
    logic                 last_ch;

    assign last_ch = (ch == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= HUNT;
            ch           <= '0;
            staging      <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    // An sof mid-frame restarts collection; stale words get overwritten.
                    if (state == COLLECT)
                        err_short <= 1'b1;
                    staging[0] <= in_data;
                    ch         <= CW'(1);
                    state      <= COLLECT;
                end else if (state == COLLECT) begin
                    staging[ch] <= in_data;
                    if (last_ch) begin
                        ch    <= '0;
                        state <= HUNT;
                        // The final sample bypasses staging so the frame publishes one clock after it.
                        if (!out_valid || out_ready) begin
                            out_data  <= {in_data, staging[N-2:0]};
                            out_valid <= 1'b1;
                        end else begin
                            err_overflow <= 1'b1;
                        end
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [16:0] cnt_sum;

    always_comb begin
        cnt_sum = 17'(err_count) + 17'(err_short) + 17'(err_overflow);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            err_count <= '0;
        else
            err_count <= cnt_sum[16] ? '1 : cnt_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized + directed bench for tdm_demux with a frame-level reference model and
// a decoupled scoreboard monitor.
module tb_tdm_demux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_sof;
    logic [N*W-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           err_short;
    logic           err_overflow;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [15:0]    err_count;
`endif

    tdm_demux #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_short    (err_short),
        .err_overflow (err_overflow)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic v;
        logic s;
        logic o;
    } rec_t;

    rec_t           cyc_q[$];
    logic [N*W-1:0] frame_q[$];

    // Reference model: a frame is just a list of samples; publication needs a free (or freeing) output.
    logic           m_inframe;
    logic           m_valid;
    logic [W-1:0]   cur[$];
    int             m_errs;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model();
        rec_t           r;
        logic           pub;
        logic [N*W-1:0] f;
        r.s = 1'b0;
        r.o = 1'b0;
        pub = 1'b0;
        f   = '0;
        if (!rst) begin
            cur.delete();
            m_inframe = 1'b0;
            m_valid   = 1'b0;
            m_errs    = 0;
        end else begin
            if (in_valid) begin
                if (in_sof) begin
                    r.s = m_inframe;
                    cur.delete();
                    cur.push_back(in_data);
                    m_inframe = 1'b1;
                end else if (m_inframe) begin
                    cur.push_back(in_data);
                    if (cur.size() == N) begin
                        if (!m_valid || out_ready) begin
                            for (int k = 0; k < N; k++) f[k*W +: W] = cur[k];
                            frame_q.push_back(f);
                            pub = 1'b1;
                        end else begin
                            r.o = 1'b1;
                        end
                        cur.delete();
                        m_inframe = 1'b0;
                    end
                end
            end
            if (pub) m_valid = 1'b1;
            else if (m_valid && out_ready) m_valid = 1'b0;
            m_errs += int'(r.s) + int'(r.o);
        end
        r.v = m_valid;
        cyc_q.push_back(r);
    endtask

    task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                        input logic r, input logic rs);
        @(negedge clk);
        in_valid  = v;
        in_sof    = s;
        in_data   = d;
        out_ready = r;
        rst       = rs;
        model();
    endtask

    task automatic idle(input logic r);
        step(1'b0, 1'b1, 8'hFF, r, 1'b1);
    endtask

    task automatic frame(input logic [N*W-1:0] f, input logic r);
        for (int k = 0; k < N; k++) step(1'b1, k == 0, f[k*W +: W], r, 1'b1);
    endtask

    // Monitor: compares per-cycle flags and every newly presented frame.
    logic           last_valid = 1'b0;
    logic [N*W-1:0] last_data  = '0;

    always @(posedge clk) begin
        rec_t r;
        logic xfer;
        #1;
        if (cyc_q.size() > 0) begin
            r = cyc_q.pop_front();
            chk("out_valid", 64'(out_valid), 64'(r.v));
            chk("err_short", 64'(err_short), 64'(r.s));
            chk("err_overflow", 64'(err_overflow), 64'(r.o));
            xfer = last_valid & out_ready;
            if (out_valid && (!last_valid || xfer)) begin
                if (frame_q.size() == 0) chk("unexpected_frame", 64'(out_data), 64'hDEAD);
                else chk("out_data", 64'(out_data), 64'(frame_q.pop_front()));
            end else if (out_valid && last_valid) begin
                chk("out_data_hold", 64'(out_data), 64'(last_data));
            end
            last_valid = out_valid;
            last_data  = out_data;
        end
    end

    initial begin
        int pos;
        logic v, s;
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
        m_inframe = 1'b0; m_valid = 1'b0; m_errs = 0;

        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1'b1);
        chk("reset_out_data", 64'(out_data), 64'h0);
        chk("reset_out_valid", 64'(out_valid), 64'h0);

        // Reset mid-frame
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h44, 1'b1, 1'b1);
        idle(1'b1);
        chk("rstmid_no_pub", 64'(out_valid), 64'h0);
        frame(32'h04030201, 1'b1);
        idle(1'b1);
        chk("rstmid_valid", 64'(out_valid), 64'h1);
        chk("rstmid_data", 64'(out_data), 64'h04030201);

        // Hunt discard
        step(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h66, 1'b1, 1'b1);
        frame(32'hA3A2A1A0, 1'b1);
        idle(1'b1);
        chk("hunt_data", 64'(out_data), 64'hA3A2A1A0);

        // Short frame
        step(1'b1, 1'b1, 8'h10, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'h20, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h21, 1'b1, 1'b1);
        chk("short_pulse", 64'(err_short), 64'h1);
        step(1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
        chk("short_one_cycle", 64'(err_short), 64'h0);
        step(1'b1, 1'b0, 8'h23, 1'b1, 1'b1);
        idle(1'b1);
        chk("short_data", 64'(out_data), 64'h23222120);
        idle(1'b1);

        // Backpressure
        frame(32'h04030201, 1'b0);
        frame(32'h08070605, 1'b0);
        idle(1'b0);
        chk("bp_hold_data", 64'(out_data), 64'h04030201);
        chk("bp_overflow", 64'(err_overflow), 64'h1);
        idle(1'b1);
        chk("bp_overflow_once", 64'(err_overflow), 64'h0);
        idle(1'b1);
        chk("bp_drained", 64'(out_valid), 64'h0);
`ifdef TDM_DEMUX_ERRCNT_EN
        chk("err_count", 64'(err_count), 64'h2);
`endif

        // Streaming, three back-to-back frames
        frame(32'h13121110, 1'b1);
        frame(32'h17161514, 1'b1);
        frame(32'h1B1A1918, 1'b1);
        idle(1'b1);
        chk("stream_last", 64'(out_data), 64'h1B1A1918);

        // Gapped frame with junk on idle cycles
        step(1'b1, 1'b1, 8'h31, 1'b1, 1'b1);
        idle(1'b1);
        step(1'b1, 1'b0, 8'h32, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h34, 1'b1, 1'b1);
        idle(1'b1);
        chk("gap_data", 64'(out_data), 64'h34333231);
        chk("gap_valid", 64'(out_valid), 64'h1);

        // Random traffic
        pos = 0;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = (pos == 0) ? 1'b1 : ($urandom_range(0, 19) == 0);
            if (v) pos = s ? 1 : (pos + 1) % N;
            step(v, s, 8'($urandom), ($urandom_range(0, 4) != 0), 1'b1);
        end
`ifdef TDM_DEMUX_ERRCNT_EN
        idle(1'b1);
        idle(1'b1);
        chk("err_count_rand", 64'(err_count), 64'(m_errs > 65535 ? 65535 : m_errs));
`endif
        for (int i = 0; i < 4; i++) idle(1'b1);
        @(posedge clk);
        #2;
        chk("frames_left", 64'(frame_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receiving end of a time-division-multiplexed sample link.
- A single W-bit lane carries N channel samples per frame, in order ch0..ch(N-1); ch0 is marked by in_sof.
- Block de-interleaves the lane into a staging register bank, then publishes a complete frame as N parallel words with a valid/ready handshake.
- Sits between the TDM link receiver and per-channel downstream consumers.

Parameters:
- N, 4, channels per frame; legal range 2..16.
- W, 8, bits per sample.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  in_data/in_sof valid this cycle.
- in_data  input  W  sample.
- in_sof  input  1  sample is ch0 of a new frame; qualified by in_valid.
- out_data  output  N*W  published frame; channel k at bits [k*W +: W].
- out_valid  output  1  out_data holds an unconsumed frame.
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
- err_short  output  1  one-cycle pulse: frame cut short by an early in_sof.
- err_overflow  output  1  one-cycle pulse: completed frame dropped, output still occupied.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=HUNT, ch=0, staging=0, out_data=0.
  - out_valid=0, err_short=0, err_overflow=0.
  - Reset takes priority over all other events, including mid-frame; any partial frame is discarded.
- Cycles with in_valid=0 change no input-side state; in_data and in_sof are ignored.
- HUNT:
  - in_valid & !in_sof: sample discarded, no error.
  - in_valid & in_sof: staging[0]<=in_data, ch<=1, go to COLLECT.
- COLLECT:
  - in_valid & in_sof: err_short pulses next cycle. Sample becomes the new ch0: staging[0]<=in_data, ch<=1, stay in COLLECT. Stale staging words are overwritten as the new frame fills.
  - in_valid & !in_sof & ch<N-1: staging[ch]<=in_data, ch<=ch+1.
  - in_valid & !in_sof & ch==N-1: frame complete. Final word is written, ch<=0, go to HUNT. The next frame must begin with in_sof.
- Publish on frame complete (evaluated in the completion cycle, register updates at that edge):
  - If out_valid==0, or out_valid & out_ready in the same cycle: out_data<={in_data, staging[N-2:0]}, out_valid<=1. Latency is 1 clk from the last sample edge to out_valid=1.
  - If out_valid & !out_ready: new frame dropped, out_data unchanged, err_overflow pulses next cycle.
- Handshake:
  - out_valid & out_ready with no completion in the same cycle clears out_valid next cycle.
  - out_data is stable while out_valid=1 and not accepted.
  - out_ready while out_valid=0 has no effect.
- Channel counter ch is clog2(N) bits and never exceeds N-1.
- Error pulses are registered, exactly one cycle wide, and independent of each other.
- A back-to-back stream (in_valid=1 every cycle) sustains full throughput when out_ready=1.

Optional Feature:
- TDM_DEMUX_ERRCNT_EN defined:
  - Adds output err_count [15:0].
  - Counts each err_short and err_overflow event; if both pulse in the same cycle, increments by 2.
  - Saturates at 16'hFFFF; cleared to 0 by reset.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan (N=4, W=8):
- Reset mid-frame: sof+11,22, then rst=0 for 1 clk, then 33,44 without sof -> nothing published, out_valid=0, state HUNT; then sof+01,02,03,04 -> out_data=32'h04030201, out_valid=1 one clk after 04.
- Hunt discard: 55,66 without sof, then sof+A0,A1,A2,A3 -> out_data=32'hA3A2A1A0, no error pulses.
- Short frame: sof+10,11, then sof+20,21,22,23 -> err_short=1 for exactly one cycle after second sof; out_data=32'h23222120.
- Backpressure: out_ready=0, two complete frames (1..4, then 5..8) -> out_data stays 32'h04030201, err_overflow pulses once after sample 8; then out_ready=1 -> out_valid drops next cycle.
- Streaming, out_ready=1, in_valid every cycle, 3 frames -> out_valid asserted on 3 completions, each with correct data, zero errors.
- Gapped input: same frame with in_valid=0 cycles inserted and in_data=FF/in_sof=1 during the gaps -> identical result to gap-free case. With TDM_DEMUX_ERRCNT_EN, after the short-frame and backpressure scenarios err_count=2.
